// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port synchronous data RAM.
// Optional out-of-range address checking is enabled by defining DMEM_ARB_RANGE_CHECK_EN.
module dmem_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int PRIO_FIXED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [31:0]       req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [31:0]       req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACC, WAIT, RSP} state_t;

  localparam int CNT_W = 2;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wait_cnt;
  logic               last_grant;
  logic               gnt0, gnt1, take;
  logic               sel_we, sel_err;
  logic [31:0]        sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               port_p1, we_p1, err_p1;
  logic [DATA_W-1:0]  rsp_rdata;

  function automatic logic out_of_range(input logic [31:0] addr);
`ifdef DMEM_ARB_RANGE_CHECK_EN
    return |addr[31:ADDR_W];
`else
    // Upper bits alias onto the RAM; referenced only to keep the port fully used.
    return 1'b0 && (|addr[31:ADDR_W]);
`endif
  endfunction

  // Arbitration: only in IDLE, never while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && rst_n) begin
      if (req0_valid && req1_valid) begin
        if (PRIO_FIXED != 0 || last_grant) gnt0 = 1'b1;
        else                               gnt1 = 1'b1;
      end else if (req0_valid) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign take      = gnt0 | gnt1;
  assign sel_we    = gnt1 ? req1_we    : req0_we;
  assign sel_addr  = gnt1 ? req1_addr  : req0_addr;
  assign sel_wdata = gnt1 ? req1_wdata : req0_wdata;
  assign sel_err   = out_of_range(sel_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (take) state_nxt = ACC;
      ACC:  state_nxt = (we_p1 || err_p1 || RD_LAT == 1) ? RSP : WAIT;
      WAIT: if (wait_cnt == '0) state_nxt = RSP;
      RSP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: request latched at the grant edge, driven to the RAM during ACC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_p1     <= 1'b0;
      we_p1       <= 1'b0;
      err_p1      <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
      last_grant  <= 1'b1;
      wait_cnt    <= '0;
    end else begin
      mem_wren <= 1'b0;
      if (take) begin
        port_p1     <= gnt1;
        we_p1       <= sel_we;
        err_p1      <= sel_err;
        mem_address <= sel_addr[ADDR_W-1:0];
        mem_data    <= sel_wdata;
        mem_wren    <= sel_we && !sel_err;
        last_grant  <= gnt1;
      end
      if (state == ACC)
        wait_cnt <= CNT_W'(RD_LAT - 2);
      else if (state == WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;
    end
  end

  assign rsp_rdata = (we_p1 || err_p1) ? '0 : mem_q;

  always_comb begin
    req0_ready = gnt0;
    req1_ready = gnt1;
    busy       = (state != IDLE);
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_rdata = '0;
    rsp1_rdata = '0;
    rsp0_err   = 1'b0;
    rsp1_err   = 1'b0;
    if (state == RSP) begin
      if (port_p1) begin
        rsp1_valid = 1'b1;
        rsp1_rdata = rsp_rdata;
        rsp1_err   = err_p1;
      end else begin
        rsp0_valid = 1'b1;
        rsp0_rdata = rsp_rdata;
        rsp0_err   = err_p1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances (RD_LAT 1/2/3, instance 1 with fixed priority),
// each with its own behavioural RAM. Expectations follow DMEM_ARB_RANGE_CHECK_EN when defined.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        req0_valid [3], req0_ready [3], req0_we [3];
  logic [31:0] req0_addr [3], req0_wdata [3];
  logic        rsp0_valid [3], rsp0_err [3];
  logic [31:0] rsp0_rdata [3];
  logic        req1_valid [3], req1_ready [3], req1_we [3];
  logic [31:0] req1_addr [3], req1_wdata [3];
  logic        rsp1_valid [3], rsp1_err [3];
  logic [31:0] rsp1_rdata [3];
  logic [5:0]  mem_address [3];
  logic [31:0] mem_data [3], mem_q [3];
  logic        mem_wren [3], busy [3];

  int checks = 0;
  int failures = 0;
  int both_ready = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] ram [64];
    logic [31:0] qd [3];

    dmem_arbiter #(
      .ADDR_W(6), .DATA_W(32), .RD_LAT(g + 1), .PRIO_FIXED(g == 1 ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid[g]), .req0_ready(req0_ready[g]), .req0_we(req0_we[g]),
      .req0_addr(req0_addr[g]), .req0_wdata(req0_wdata[g]),
      .rsp0_valid(rsp0_valid[g]), .rsp0_rdata(rsp0_rdata[g]), .rsp0_err(rsp0_err[g]),
      .req1_valid(req1_valid[g]), .req1_ready(req1_ready[g]), .req1_we(req1_we[g]),
      .req1_addr(req1_addr[g]), .req1_wdata(req1_wdata[g]),
      .rsp1_valid(rsp1_valid[g]), .rsp1_rdata(rsp1_rdata[g]), .rsp1_err(rsp1_err[g]),
      .mem_address(mem_address[g]), .mem_data(mem_data[g]), .mem_wren(mem_wren[g]),
      .mem_q(mem_q[g]), .busy(busy[g])
    );

    always @(posedge clk) begin
      if (mem_wren[g]) ram[mem_address[g]] <= mem_data[g];
      qd[0] <= ram[mem_address[g]];
      qd[1] <= qd[0];
      qd[2] <= qd[1];
    end
    assign mem_q[g] = qd[g];
  end

  always @(negedge clk) begin
    #2;
    for (int m = 0; m < 3; m++)
      if (req0_ready[m] && req1_ready[m]) both_ready++;
  end

  task automatic set_req(input int k, input int p, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      req0_valid[k] = v; req0_we[k] = we; req0_addr[k] = a; req0_wdata[k] = d;
    end else begin
      req1_valid[k] = v; req1_we[k] = we; req1_addr[k] = a; req1_wdata[k] = d;
    end
  endtask

  function automatic logic rdy(input int k, input int p);
    return (p == 0) ? req0_ready[k] : req1_ready[k];
  endfunction

  function automatic logic rspv(input int k, input int p);
    return (p == 0) ? rsp0_valid[k] : rsp1_valid[k];
  endfunction

  // One transaction; lat is the response cycle counted from the grant cycle (-1 if none).
  task automatic txn(input int k, input int p, input logic we, input logic [31:0] a,
                     input logic [31:0] d, output int lat, output logic [31:0] rd,
                     output logic err, output int wren_n, output int other_n);
    int n;
    lat = -1; rd = '0; err = 1'b0; wren_n = 0; other_n = 0;
    @(negedge clk);
    set_req(k, p, 1'b1, we, a, d);
    #1;
    n = 0;
    while (!rdy(k, p) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      set_req(k, p, 1'b0, 1'b0, '0, '0);
      return;
    end
    @(negedge clk);
    set_req(k, p, 1'b0, 1'b0, '0, '0);
    #1;
    for (int c = 1; c <= 8; c++) begin
      if (mem_wren[k]) wren_n++;
      if (rspv(k, 1 - p)) other_n++;
      if (rspv(k, p)) begin
        lat = c;
        rd  = (p == 0) ? rsp0_rdata[k] : rsp1_rdata[k];
        err = (p == 0) ? rsp0_err[k] : rsp1_err[k];
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0;
    set_req(0, 0, 1'b1, 1'b1, 32'd3, 32'h11);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req0_ready[0] !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", req0_ready[0]); end
    checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy[0]); end
    checks++; if (mem_wren[0] !== 1'b0) begin failures++; $display("FAIL rst_wren got=%0b exp=0", mem_wren[0]); end
    checks++; if (mem_address[0] !== 6'd0) begin failures++; $display("FAIL rst_addr got=%0h exp=0", mem_address[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (req0_ready[0] !== 1'b1) begin failures++; $display("FAIL grant_after_rst got=%0b exp=1", req0_ready[0]); end
    @(negedge clk);
    set_req(0, 0, 1'b0, 1'b0, '0, '0);
    #1;
    checks++; if (mem_wren[0] !== 1'b1) begin failures++; $display("FAIL acc_wren got=%0b exp=1", mem_wren[0]); end
    checks++; if (mem_address[0] !== 6'd3) begin failures++; $display("FAIL acc_addr got=%0h exp=3", mem_address[0]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_wren[0] !== 1'b0) begin failures++; $display("FAIL midrst_wren got=%0b exp=0", mem_wren[0]); end
    checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", busy[0]); end
    checks++; if (mem_address[0] !== 6'd0 || mem_data[0] !== 32'd0) begin failures++; $display("FAIL midrst_memout got=%0h/%0h exp=0/0", mem_address[0], mem_data[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      #1;
      if (rsp0_valid[0] || rsp1_valid[0]) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_rsp got=%0d exp=0", seen); end
  endtask

  task automatic test_arbitration();
    int seq [4];
    int n, cyc, expv;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_req(k, 0, 1'b1, 1'b0, 32'd5, '0);
      set_req(k, 1, 1'b1, 1'b0, 32'd9, '0);
      n = 0; cyc = 0;
      while (n < 4 && cyc < 60) begin
        #1;
        if (req0_ready[k]) begin seq[n] = 0; n++; end
        else if (req1_ready[k]) begin seq[n] = 1; n++; end
        @(negedge clk);
        cyc++;
      end
      set_req(k, 0, 1'b0, 1'b0, '0, '0);
      set_req(k, 1, 1'b0, 1'b0, '0, '0);
      repeat (8) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        expv = (k == 1) ? 0 : (i % 2);
        checks++;
        if (n <= i || seq[i] !== expv) begin
          failures++; $display("FAIL arb_inst%0d_grant%0d got=%0d exp=%0d", k, i, (n <= i) ? -1 : seq[i], expv);
        end
      end
    end
  endtask

  task automatic test_write_read();
    int lat, wn, on;
    logic [31:0] rd;
    logic err;
    txn(0, 0, 1'b1, 32'd5, 32'hDEADBEEF, lat, rd, err, wn, on);
    checks++; if (lat !== 2) begin failures++; $display("FAIL wr_lat got=%0d exp=2", lat); end
    checks++; if (wn !== 1) begin failures++; $display("FAIL wr_wren_cycles got=%0d exp=1", wn); end
    checks++; if (rd !== 32'd0 || err !== 1'b0) begin failures++; $display("FAIL wr_rsp got=%0h/%0b exp=0/0", rd, err); end
    txn(0, 0, 1'b0, 32'd5, 32'd0, lat, rd, err, wn, on);
    checks++; if (lat !== 2) begin failures++; $display("FAIL rd_lat got=%0d exp=2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%0h exp=deadbeef", rd); end
    checks++; if (wn !== 0) begin failures++; $display("FAIL rd_wren_cycles got=%0d exp=0", wn); end
  endtask

  task automatic test_wrap();
    int lat, wn, on;
    logic [31:0] rd;
    logic err;
    txn(0, 1, 1'b1, 32'd63, 32'd7, lat, rd, err, wn, on);
    checks++; if (lat !== 2 || wn !== 1) begin failures++; $display("FAIL w63 got=lat%0d/wren%0d exp=lat2/wren1", lat, wn); end
    txn(0, 1, 1'b1, 32'd0, 32'h55, lat, rd, err, wn, on);
    txn(0, 1, 1'b1, 32'd64, 32'h99, lat, rd, err, wn, on);
`ifdef DMEM_ARB_RANGE_CHECK_EN
    checks++; if (lat !== 2 || wn !== 0 || err !== 1'b1) begin failures++; $display("FAIL w64 got=lat%0d/wren%0d/err%0b exp=lat2/wren0/err1", lat, wn, err); end
`else
    checks++; if (lat !== 2 || wn !== 1 || err !== 1'b0) begin failures++; $display("FAIL w64 got=lat%0d/wren%0d/err%0b exp=lat2/wren1/err0", lat, wn, err); end
`endif
    txn(0, 1, 1'b0, 32'd64, 32'd0, lat, rd, err, wn, on);
`ifdef DMEM_ARB_RANGE_CHECK_EN
    checks++; if (lat !== 2 || rd !== 32'd0 || err !== 1'b1) begin failures++; $display("FAIL r64 got=lat%0d/%0h/err%0b exp=lat2/0/err1", lat, rd, err); end
`else
    checks++; if (lat !== 2 || rd !== 32'h99 || err !== 1'b0) begin failures++; $display("FAIL r64 got=lat%0d/%0h/err%0b exp=lat2/99/err0", lat, rd, err); end
`endif
    txn(0, 1, 1'b0, 32'd0, 32'd0, lat, rd, err, wn, on);
`ifdef DMEM_ARB_RANGE_CHECK_EN
    checks++; if (rd !== 32'h55) begin failures++; $display("FAIL r0 got=%0h exp=55", rd); end
`else
    checks++; if (rd !== 32'h99) begin failures++; $display("FAIL r0 got=%0h exp=99", rd); end
`endif
    txn(0, 1, 1'b0, 32'd63, 32'd0, lat, rd, err, wn, on);
    checks++; if (rd !== 32'd7 || err !== 1'b0) begin failures++; $display("FAIL r63 got=%0h/%0b exp=7/0", rd, err); end
  endtask

  task automatic test_latency();
    int lat, wn, on;
    logic [31:0] rd;
    logic err;
    for (int k = 0; k < 3; k++) begin
      txn(k, 1, 1'b1, 32'd12, 32'h1000 + k, lat, rd, err, wn, on);
      checks++; if (lat !== 2 || on !== 0) begin failures++; $display("FAIL lat_wr_inst%0d got=lat%0d/other%0d exp=lat2/other0", k, lat, on); end
      txn(k, 0, 1'b0, 32'd12, 32'd0, lat, rd, err, wn, on);
      checks++; if (lat !== 2 + k) begin failures++; $display("FAIL lat_rd_inst%0d got=%0d exp=%0d", k, lat, 2 + k); end
      checks++; if (rd !== 32'h1000 + k || on !== 0) begin failures++; $display("FAIL lat_data_inst%0d got=%0h/other%0d exp=%0h/other0", k, rd, on, 32'h1000 + k); end
    end
    checks++; if (both_ready !== 0) begin failures++; $display("FAIL both_ready got=%0d exp=0", both_ready); end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      set_req(k, 0, 1'b0, 1'b0, '0, '0);
      set_req(k, 1, 1'b0, 1'b0, '0, '0);
    end
    test_reset();
    test_arbitration();
    test_write_read();
    test_wrap();
    test_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
